// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and word-wide instruction-memory write port of the boot loader.
interface imem_boot_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  // Stream producer / memory sink side.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata
  );

  // Boot loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them to
// instruction memory and holds the core until the requested word count is loaded.
module imem_boot_loader #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [15:0]         i_len_words,
  imem_boot_loader_if.slave   bus,
  output logic                o_core_hold,
  output logic                o_done,
  output logic                o_err,
  output logic [15:0]         o_words_loaded,
  output logic [7:0]          o_checksum
);

  localparam logic [31:0] MemWords = 32'(MEM_BYTES / 4);

  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StDone, StErr} state_e;

  state_e      r_state;
  logic [1:0]  r_byte_idx;
  logic [15:0] r_len;
  logic [15:0] r_words;
  logic [7:0]  r_checksum;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_in_ready;
  logic        r_mem_we;
  logic        r_done;
  logic        r_err;
  logic        r_core_hold;

  logic        w_accept;
  logic        w_len_zero;
  logic        w_len_over;
  logic [15:0] w_words_next;

  // in_ready is a register, so the handshake never feeds back into it combinationally.
  assign w_accept     = r_in_ready & bus.in_valid;
  assign w_len_zero   = (i_len_words == 16'd0);
  assign w_len_over   = ({16'd0, i_len_words} > MemWords);
  assign w_words_next = r_words + 16'd1;

  // Load FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_byte_idx  <= 2'd0;
      r_len       <= 16'd0;
      r_words     <= 16'd0;
      r_checksum  <= 8'd0;
      r_waddr     <= BASE_ADDR;
      r_wdata     <= 32'd0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_core_hold <= 1'b1;
    end else begin
      unique case (r_state)
        StIdle, StDone, StErr: begin
          if (i_start) begin
            r_byte_idx <= 2'd0;
            r_len      <= i_len_words;
            r_words    <= 16'd0;
            r_checksum <= 8'd0;
            r_waddr    <= BASE_ADDR;
            if (w_len_zero) begin
              r_state     <= StDone;
              r_done      <= 1'b1;
              r_err       <= 1'b0;
              r_core_hold <= 1'b0;
              r_in_ready  <= 1'b0;
            end else if (w_len_over) begin
              r_state     <= StErr;
              r_done      <= 1'b0;
              r_err       <= 1'b1;
              r_core_hold <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_state     <= StLoad;
              r_done      <= 1'b0;
              r_err       <= 1'b0;
              r_core_hold <= 1'b1;
              r_in_ready  <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (w_accept) begin
            r_wdata[8*r_byte_idx +: 8] <= bus.in_data;
            r_checksum                 <= r_checksum + bus.in_data;
            r_byte_idx                 <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_state    <= StWrite;
              r_in_ready <= 1'b0;
              r_mem_we   <= 1'b1;
            end
          end
        end
        StWrite: begin
          r_mem_we <= 1'b0;
          r_words  <= w_words_next;
          r_waddr  <= r_waddr + 32'd4;
          if (w_words_next == r_len) begin
            r_state     <= StDone;
            r_done      <= 1'b1;
            r_core_hold <= 1'b0;
          end else begin
            r_state    <= StLoad;
            r_in_ready <= 1'b1;
            r_byte_idx <= 2'd0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_waddr  = r_waddr;
  assign bus.mem_wdata  = r_wdata;
  assign o_core_hold    = r_core_hold;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_words_loaded = r_words;
  assign o_checksum     = r_checksum;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: loads, backpressure, boundaries, reset abort.
module tb_imem_boot_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] len_words;
  logic        core_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;
  logic [7:0]  checksum;

  imem_boot_loader_if bus ();

  imem_boot_loader #(
    .MEM_BYTES (1024),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_len_words    (len_words),
    .bus            (bus.slave),
    .o_core_hold    (core_hold),
    .o_done         (done),
    .o_err          (err),
    .o_words_loaded (words_loaded),
    .o_checksum     (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every memory write mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      q_addr.push_back(bus.mem_waddr);
      q_data.push_back(bus.mem_wdata);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] len);
    start     = 1'b1;
    len_words = len;
    step();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit took;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    do begin
      took = bus.in_ready;
      step();
      n++;
    end while (!took && n < 50);
    if (!took) check_eq("byte_accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    check_eq("wait_done", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] full_word(input int w);
    return 32'h9E37_79B9 * 32'(w + 1);
  endfunction

  initial begin
    int base;
    logic [7:0]  exp_sum;
    logic [31:0] fw;

    reset        = 1'b1;
    start        = 1'b0;
    len_words    = 16'd0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;

    // Reset state
    step();
    step();
    check_eq("rst_core_hold", 32'(core_hold), 32'd1);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_waddr", bus.mem_waddr, 32'd0);
    check_eq("rst_checksum", 32'(checksum), 32'd0);
    check_eq("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    step();

    // Two-word load, back-to-back bytes
    pulse_start(16'd2);
    check_eq("two_ready_after_start", 32'(bus.in_ready), 32'd1);
    send_word(32'h0050_8413, 0);
    send_word(32'h0041_0503, 0);
    check_eq("two_last_we", 32'(bus.mem_we), 32'd1);
    step();
    check_eq("two_done_next", 32'(done), 32'd1);
    check_eq("two_we_low", 32'(bus.mem_we), 32'd0);
    check_eq("two_core_hold", 32'(core_hold), 32'd0);
    check_eq("two_words", 32'(words_loaded), 32'd2);
    check_eq("two_checksum", 32'(checksum), 32'h30);
    check_eq("two_nwrites", 32'(q_addr.size()), 32'd2);
    if (q_addr.size() == 2) begin
      check_eq("two_addr0", q_addr[0], 32'd0);
      check_eq("two_data0", q_data[0], 32'h0050_8413);
      check_eq("two_addr1", q_addr[1], 32'd4);
      check_eq("two_data1", q_data[1], 32'h0041_0503);
      check_eq("two_spacing", 32'(q_cyc[1] - q_cyc[0]), 32'd5);
    end

    // Backpressure reload from DONE, with a stray start during LOAD
    base = q_addr.size();
    pulse_start(16'd2);
    check_eq("bp_hold_rises", 32'(core_hold), 32'd1);
    send_byte(8'h13, 3);
    send_byte(8'h84, 1);
    start     = 1'b1;
    len_words = 16'd0;
    step();
    start     = 1'b0;
    step();
    send_byte(8'h50, 3);
    send_byte(8'h00, 3);
    send_word(32'h0041_0503, 3);
    wait_done(20);
    check_eq("bp_words", 32'(words_loaded), 32'd2);
    check_eq("bp_checksum", 32'(checksum), 32'h30);
    check_eq("bp_nwrites", 32'(q_addr.size() - base), 32'd2);
    if (q_addr.size() == base + 2) begin
      check_eq("bp_addr0", q_addr[base], 32'd0);
      check_eq("bp_data0", q_data[base], 32'h0050_8413);
      check_eq("bp_addr1", q_addr[base+1], 32'd4);
      check_eq("bp_data1", q_data[base+1], 32'h0041_0503);
    end

    // Zero-length load
    base = q_addr.size();
    pulse_start(16'd0);
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("zero_hold", 32'(core_hold), 32'd0);
    check_eq("zero_words", 32'(words_loaded), 32'd0);
    step();
    step();
    check_eq("zero_nwrites", 32'(q_addr.size() - base), 32'd0);

    // Over-length request
    pulse_start(16'd257);
    check_eq("over_err", 32'(err), 32'd1);
    check_eq("over_hold", 32'(core_hold), 32'd1);
    check_eq("over_ready", 32'(bus.in_ready), 32'd0);
    check_eq("over_done", 32'(done), 32'd0);

    // Legal single-word load out of ERR
    base = q_addr.size();
    pulse_start(16'd1);
    check_eq("one_err_clear", 32'(err), 32'd0);
    send_word(32'h1234_5678, 0);
    wait_done(5);
    check_eq("one_nwrites", 32'(q_addr.size() - base), 32'd1);
    if (q_addr.size() == base + 1) begin
      check_eq("one_addr", q_addr[base], 32'd0);
      check_eq("one_data", q_data[base], 32'h1234_5678);
    end
    check_eq("one_checksum", 32'(checksum), 32'h14);

    // Full capacity
    base    = q_addr.size();
    exp_sum = 8'd0;
    pulse_start(16'd256);
    for (int w = 0; w < 256; w++) begin
      fw = full_word(w);
      exp_sum = exp_sum + fw[7:0] + fw[15:8] + fw[23:16] + fw[31:24];
      send_word(fw, 0);
    end
    wait_done(5);
    repeat (4) step();
    check_eq("full_nwrites", 32'(q_addr.size() - base), 32'd256);
    if (q_addr.size() == base + 256) begin
      check_eq("full_last_addr", q_addr[base+255], 32'h3FC);
      check_eq("full_last_data", q_data[base+255], full_word(255));
      check_eq("full_addr100", q_addr[base+100], 32'd400);
    end
    check_eq("full_words", 32'(words_loaded), 32'd256);
    check_eq("full_checksum", 32'(checksum), 32'(exp_sum));

    // Reset in the middle of the second word
    base = q_addr.size();
    pulse_start(16'd2);
    send_word(32'hAABB_CCDD, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    step();
    check_eq("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check_eq("mid_rst_hold", 32'(core_hold), 32'd1);
    check_eq("mid_rst_waddr", bus.mem_waddr, 32'd0);
    check_eq("mid_rst_checksum", 32'(checksum), 32'd0);
    check_eq("mid_rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    repeat (6) step();
    check_eq("mid_rst_nwrites", 32'(q_addr.size() - base), 32'd1);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    base = q_addr.size();
    pulse_start(16'd1);
    send_word(32'hCAFE_F00D, 0);
    wait_done(5);
    check_eq("fresh_nwrites", 32'(q_addr.size() - base), 32'd1);
    if (q_addr.size() == base + 1) begin
      check_eq("fresh_addr", q_addr[base], 32'd0);
      check_eq("fresh_data", q_data[base], 32'hCAFE_F00D);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
